// File: rtl/shift_register_universal_pkg.sv
`default_nettype none
// ============================================================================
// Module : shift_register_universal_pkg
// Brief  : Operation codes and decode helpers for the universal shift register.
// Rev    : 1.0
// ============================================================================
package shift_register_universal_pkg;

  typedef enum logic [2:0] {
    SR_HOLD  = 3'd0,
    SR_SHR   = 3'd1,
    SR_SHL   = 3'd2,
    SR_ROR   = 3'd3,
    SR_ROL   = 3'd4,
    SR_LOAD  = 3'd5,
    SR_CLEAR = 3'd6,
    SR_RSVD  = 3'd7
  } sr_mode_e;

  // Shifts and rotates advance the frame counter.
  function automatic logic is_step(input sr_mode_e m);
    return (m == SR_SHR) || (m == SR_SHL) || (m == SR_ROR) || (m == SR_ROL);
  endfunction

  // Load and clear start a fresh frame.
  function automatic logic is_restart(input sr_mode_e m);
    return (m == SR_LOAD) || (m == SR_CLEAR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_register_universal_frame_counter.sv
`default_nettype none
// ============================================================================
// Module : frame_counter
// Brief  : Counts steps within a STEPS-long frame and pulses done on the last.
// Rev    : 1.0
// ============================================================================
module frame_counter #(
  parameter int STEPS = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic          done
);

  localparam logic [CW-1:0] c_LAST = CW'(STEPS - 1);

  logic [CW-1:0] r_count;
  logic          r_done;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
      r_done  <= 1'b0;
    end else if (step) begin
      if (r_count == c_LAST) begin
        r_count <= '0;
        r_done  <= 1'b1;
      end else begin
        r_count <= r_count + 1'b1;
        r_done  <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign count = r_count;
  assign done  = r_done;

endmodule
`default_nettype wire

// File: rtl/shift_register_universal.sv
`default_nettype none
// ============================================================================
// Module : shift_register_universal
// Brief  : W-bit shift/rotate/load register moving S bits per step, with frame flag.
// Rev    : 1.0
// ============================================================================
module shift_register_universal
  import shift_register_universal_pkg::*;
#(
  parameter  int W     = 8,
  parameter  int S     = 1,
  localparam int STEPS = W / S,
  localparam int CW    = $clog2(STEPS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [2:0]    mode,
  input  logic [W-1:0]  load_data,
  input  logic [S-1:0]  sin_msb,
  input  logic [S-1:0]  sin_lsb,
  output logic [W-1:0]  out,
  output logic [S-1:0]  sout_lsb,
  output logic [S-1:0]  sout_msb,
  output logic [CW-1:0] count,
  output logic          frame_done
);

  if (W < 2 || S < 1 || S >= W || (W % S) != 0) begin : g_bad_params
    $error("shift_register_universal: need W >= 2, 1 <= S < W and W %% S == 0");
  end

  sr_mode_e     w_mode;
  logic         w_step;
  logic         w_clr;
  logic [W-1:0] r_out;

  assign w_mode = sr_mode_e'(mode);
  assign w_step = en && is_step(w_mode);
  assign w_clr  = en && is_restart(w_mode);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else if (en) begin
      case (w_mode)
        SR_SHR:   r_out <= {sin_msb, r_out[W-1:S]};
        SR_SHL:   r_out <= {r_out[W-S-1:0], sin_lsb};
        SR_ROR:   r_out <= {r_out[S-1:0], r_out[W-1:S]};
        SR_ROL:   r_out <= {r_out[W-S-1:0], r_out[W-1 -: S]};
        SR_LOAD:  r_out <= load_data;
        SR_CLEAR: r_out <= '0;
        default:  r_out <= r_out;
      endcase
    end
  end

  frame_counter #(
    .STEPS (STEPS),
    .CW    (CW)
  ) u_frame_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .step  (w_step),
    .count (count),
    .done  (frame_done)
  );

  assign out      = r_out;
  assign sout_lsb = r_out[S-1:0];
  assign sout_msb = r_out[W-1 -: S];

endmodule
`default_nettype wire

// File: tb/tb_shift_register_universal.sv
`default_nettype none
// ============================================================================
// Module : tb_shift_register_universal
// Brief  : Bench for S=1 and S=2 instances against a reference model.
// Rev    : 1.0
// ============================================================================
module tb_shift_register_universal;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [7:0] load_data;
  logic [0:0] sin_msb_a, sin_lsb_a;
  logic [1:0] sin_msb_b, sin_lsb_b;

  logic [7:0] out_a, out_b;
  logic [0:0] sout_lsb_a, sout_msb_a;
  logic [1:0] sout_lsb_b, sout_msb_b;
  logic [3:0] count_a;
  logic [2:0] count_b;
  logic       fd_a, fd_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_register_universal #(.W(8), .S(1)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load_data(load_data),
    .sin_msb(sin_msb_a), .sin_lsb(sin_lsb_a), .out(out_a),
    .sout_lsb(sout_lsb_a), .sout_msb(sout_msb_a), .count(count_a), .frame_done(fd_a)
  );

  shift_register_universal #(.W(8), .S(2)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load_data(load_data),
    .sin_msb(sin_msb_b), .sin_lsb(sin_lsb_b), .out(out_b),
    .sout_lsb(sout_lsb_b), .sout_msb(sout_msb_b), .count(count_b), .frame_done(fd_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: register as plain arithmetic, counter as total steps since restart.
  function automatic logic [7:0] nxt(input logic [7:0] v, input logic [2:0] m,
                                     input logic [7:0] ld, input int s,
                                     input logic [7:0] smsb, input logic [7:0] slsb);
    case (m)
      3'd1:    return (v >> s) | (smsb << (8 - s));
      3'd2:    return (v << s) | slsb;
      3'd3:    return (v >> s) | (v << (8 - s));
      3'd4:    return (v << s) | (v >> (8 - s));
      3'd5:    return ld;
      3'd6:    return 8'h00;
      default: return v;
    endcase
  endfunction

  logic [7:0] m_a, m_b;
  int         n_steps;
  logic       m_fd_a, m_fd_b;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    logic stepped;
    if (rst) begin
      m_a = 8'h00; m_b = 8'h00; n_steps = 0; m_fd_a = 1'b0; m_fd_b = 1'b0;
    end else begin
      stepped = en && (mode >= 3'd1) && (mode <= 3'd4);
      if (en) begin
        m_a = nxt(m_a, mode, load_data, 1, {7'b0, sin_msb_a}, {7'b0, sin_lsb_a});
        m_b = nxt(m_b, mode, load_data, 2, {6'b0, sin_msb_b}, {6'b0, sin_lsb_b});
      end
      if (en && (mode == 3'd5 || mode == 3'd6)) n_steps = 0;
      else if (stepped) n_steps++;
      m_fd_a = stepped && (n_steps % 8 == 0);
      m_fd_b = stepped && (n_steps % 4 == 0);
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("out_a",      out_a,      m_a);
      chk("sout_lsb_a", sout_lsb_a, m_a[0]);
      chk("sout_msb_a", sout_msb_a, m_a[7]);
      chk("count_a",    count_a,    n_steps % 8);
      chk("fd_a",       fd_a,       m_fd_a);
      chk("out_b",      out_b,      m_b);
      chk("sout_lsb_b", sout_lsb_b, m_b[1:0]);
      chk("sout_msb_b", sout_msb_b, m_b[7:6]);
      chk("count_b",    count_b,    n_steps % 4);
      chk("fd_b",       fd_b,       m_fd_b);
    end
  end

  // Apply one cycle of inputs at a falling edge; returns at the next falling edge.
  task automatic cyc(input logic e, input logic [2:0] m, input logic [7:0] ld,
                     input logic [1:0] sm, input logic [1:0] sl);
    rst = 1'b0; en = e; mode = m; load_data = ld;
    sin_msb_a = sm[0]; sin_lsb_a = sl[0]; sin_msb_b = sm; sin_lsb_b = sl;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] legacy_bits;
    logic [1:0] exp_sm [4];
    exp_sm = '{2'd2, 2'd3, 2'd1, 2'd0};
    legacy_bits = 8'b1000_1101;

    rst = 1'b1; en = 1'b0; mode = 3'd0; load_data = 8'h00;
    sin_msb_a = '0; sin_lsb_a = '0; sin_msb_b = '0; sin_lsb_b = '0;
    @(negedge clk); @(negedge clk);
    chk("reset out_a", out_a, 8'h00);
    chk("reset count_a", count_a, 4'd0);
    chk("reset fd_a", fd_a, 1'b0);

    // Legacy S=1 shift right: first bit in ends at out[0].
    cyc(1'b1, 3'd5, 8'h00, 2'b00, 2'b00);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 3'd1, 8'h00, {2{legacy_bits[i]}}, 2'b00);
      chk("legacy fd_a", fd_a, (i == 7));
    end
    chk("legacy out_a", out_a, 8'h8D);
    chk("legacy count_a", count_a, 4'd0);

    // S=2 deserialize/serialize.
    cyc(1'b1, 3'd5, 8'hB4, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) begin
      chk("ser sout_msb_b", sout_msb_b, exp_sm[i]);
      cyc(1'b1, 3'd2, 8'h00, 2'b00, 2'b11);
      chk("ser fd_b", fd_b, (i == 3));
    end
    chk("ser out_b", out_b, 8'hFF);

    // Rotates.
    cyc(1'b1, 3'd5, 8'h81, 2'b00, 2'b00);
    cyc(1'b1, 3'd4, 8'h00, 2'b00, 2'b00);
    chk("rol out_a", out_a, 8'h03);
    cyc(1'b1, 3'd3, 8'h00, 2'b00, 2'b00);
    cyc(1'b1, 3'd3, 8'h00, 2'b00, 2'b00);
    chk("ror out_a", out_a, 8'hC0);
    cyc(1'b1, 3'd5, 8'h81, 2'b00, 2'b00);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 3'd4, 8'h00, 2'b00, 2'b00);
      chk("rol8 fd_a", fd_a, (i == 7));
    end
    chk("rol8 out_a", out_a, 8'h81);

    // Mid-frame abort.
    cyc(1'b1, 3'd6, 8'h00, 2'b00, 2'b00);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 3'd1, 8'h00, 2'b01, 2'b00);
      chk("abort pre fd_a", fd_a, 1'b0);
    end
    cyc(1'b1, 3'd6, 8'h00, 2'b00, 2'b00);
    chk("abort clr count_a", count_a, 4'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 3'd1, 8'h00, 2'b01, 2'b00);
      chk("abort post fd_a", fd_a, (i == 7));
    end

    // Hold / enable: LOAD 5A then 3 shifts leaves A=0B, B=01, count 3.
    cyc(1'b1, 3'd5, 8'h5A, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) cyc(1'b1, 3'd1, 8'h00, 2'b00, 2'b00);
    for (int i = 0; i < 10; i++) begin
      case (i % 3)
        0:       cyc(1'b0, 3'($urandom_range(0, 7)), 8'($urandom), 2'($urandom), 2'($urandom));
        1:       cyc(1'b1, 3'd0, 8'($urandom), 2'($urandom), 2'($urandom));
        default: cyc(1'b1, 3'd7, 8'($urandom), 2'($urandom), 2'($urandom));
      endcase
      chk("hold out_a", out_a, 8'h0B);
      chk("hold count_a", count_a, 4'd3);
      chk("hold fd_a", fd_a, 1'b0);
      chk("hold out_b", out_b, 8'h01);
      chk("hold count_b", count_b, 3'd3);
    end

    // Reset mid-stream while shifting.
    cyc(1'b1, 3'd1, 8'h00, 2'b11, 2'b00);
    cyc(1'b1, 3'd1, 8'h00, 2'b11, 2'b00);
    rst = 1'b1; en = 1'b1; mode = 3'd1;
    @(negedge clk);
    chk("rst out_a", out_a, 8'h00);
    chk("rst count_a", count_a, 4'd0);
    chk("rst fd_a", fd_a, 1'b0);
    chk("rst out_b", out_b, 8'h00);

    // Randomized traffic, biased toward steps so frames complete.
    for (int i = 0; i < 600; i++) begin
      logic [2:0] m;
      m = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
      cyc(($urandom_range(0, 7) != 0), m, 8'($urandom), 2'($urandom), 2'($urandom));
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        @(negedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
